// File: rtl/axi_parameters.sv
// Shared widths, burst/response encodings and FSM state types for the AXI4 slave memory.
package axi_parameters;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 9;
  localparam int AXI_DEPTH      = 256;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi4_addr_gen.sv
// Combinational beat-address step and per-beat error check for one AXI burst path.
module axi4_addr_gen
  import axi_parameters::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int DEPTH      = AXI_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  localparam int OFFS = $clog2(DATA_WIDTH/8);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    incr_addr = addr + step;
    case (burst)
      FIXED:   next_addr = addr;
      // wrap window is power-of-two sized for every legal WRAP length
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
    idx = addr[OFFS +: IDX_W];
    err = ((addr >> OFFS) >= ADDR_WIDTH'(DEPTH)) ||
          (size > 3'(OFFS)) ||
          (burst == 2'b11) ||
          ((burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed memory; independent write and read burst engines.
// state  | meaning
// W_IDLE | accepting AW
// W_DATA | accepting W beats until AWLEN+1 received
// W_RESP | presenting B until BREADY
// R_IDLE | accepting AR
// R_DATA | presenting R beats until the RLAST handshake
module axi4_slave_mem
  import axi_parameters::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int DEPTH      = AXI_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W = DATA_WIDTH/8;
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  ports_en;

  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_next_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err, w_gen_err, w_beat_err, w_last_beat;
  logic [IDX_W-1:0]      w_idx;
  logic                  aw_fire, w_fire, b_fire;

  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, rg_addr, r_next_addr;
  logic [7:0]            r_len, rg_len, r_cnt;
  logic [2:0]            r_size, rg_size;
  logic [1:0]            r_burst, rg_burst;
  logic                  r_gen_err;
  logic [IDX_W-1:0]      r_idx;
  logic                  ar_fire, r_fire;

  axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_wgen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
    .next_addr(w_next_addr), .idx(w_idx), .err(w_gen_err)
  );

  axi4_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_rgen (
    .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
    .next_addr(r_next_addr), .idx(r_idx), .err(r_gen_err)
  );

  // holds the address-channel readies low until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ports_en <= 1'b0;
    else        ports_en <= 1'b1;
  end

  assign aw_fire     = AWVALID && AWREADY;
  assign w_fire      = WVALID && WREADY;
  assign b_fire      = BVALID && BREADY;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = w_gen_err || (WLAST != w_last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_next = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_fire) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = ports_en && (w_state == W_IDLE);
    WREADY  = (w_state == W_DATA);
    BVALID  = (w_state == W_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      BID     <= '0;
      BRESP   <= OKAY;
    end else begin
      if (aw_fire) begin
        w_id    <= AWID;
        w_addr  <= AWADDR;
        w_len   <= AWLEN;
        w_size  <= AWSIZE;
        w_burst <= AWBURST;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_fire) begin
        w_addr <= w_next_addr;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err || w_beat_err;
        if (w_last_beat) begin
          BID   <= w_id;
          BRESP <= (w_err || w_beat_err) ? SLVERR : OKAY;
        end
      end
    end
  end

  // memory contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_fire && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  assign ar_fire = ARVALID && ARREADY;
  assign r_fire  = RVALID && RREADY;

  // in R_IDLE the generator checks the AR beat itself; afterwards the next beat to fetch
  always_comb begin
    rg_addr  = r_addr;
    rg_len   = r_len;
    rg_size  = r_size;
    rg_burst = r_burst;
    if (r_state == R_IDLE) begin
      rg_addr  = ARADDR;
      rg_len   = ARLEN;
      rg_size  = ARSIZE;
      rg_burst = ARBURST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (r_fire && RLAST) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = ports_en && (r_state == R_IDLE);
    RVALID  = (r_state == R_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      RID     <= '0;
      RDATA   <= '0;
      RRESP   <= OKAY;
      RLAST   <= 1'b0;
    end else if (ar_fire) begin
      RID     <= ARID;
      r_len   <= ARLEN;
      r_size  <= ARSIZE;
      r_burst <= ARBURST;
      r_addr  <= r_next_addr;
      r_cnt   <= '0;
      RLAST   <= (ARLEN == 8'd0);
      RDATA   <= r_gen_err ? '0 : mem[r_idx];
      RRESP   <= r_gen_err ? SLVERR : OKAY;
    end else if (r_fire) begin
      if (RLAST) begin
        RLAST <= 1'b0;
      end else begin
        r_addr <= r_next_addr;
        r_cnt  <= r_cnt + 8'd1;
        RLAST  <= ((r_cnt + 8'd1) == r_len);
        RDATA  <= r_gen_err ? '0 : mem[r_idx];
        RRESP  <= r_gen_err ? SLVERR : OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: expected B/R responses queued at stimulus time.
module tb_axi4_slave_mem;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 9;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] AWID = '0, ARID = '0, BID, RID;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]    AWLEN = '0, ARLEN = '0;
  logic [2:0]    AWSIZE = '0, ARSIZE = '0;
  logic [1:0]    AWBURST = '0, ARBURST = '0, BRESP, RRESP;
  logic          AWVALID = 1'b0, ARVALID = 1'b0, WVALID = 1'b0, WLAST = 1'b0;
  logic          BREADY = 1'b0, RREADY = 1'b0;
  logic [DW-1:0] WDATA = '0, RDATA;
  logic [3:0]    WSTRB = '0;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;

  axi4_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} bexp_t;
  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rexp_t;

  bexp_t b_q[$];
  rexp_t r_q[$];
  logic [DW-1:0] model [DEPTH];
  int checks = 0;
  int failures = 0;

  logic [IW-1:0] wa_id;
  logic [AW-1:0] wa_addr;
  logic [7:0]    wa_len;
  logic [2:0]    wa_size;
  logic [1:0]    wa_burst;
  int            wa_beat;
  logic          wa_err;

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] start, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
    longint unsigned s, bytes, span, base;
    s = 64'(start);
    bytes = 64'd1 << size;
    span = (64'(len) + 64'd1) * bytes;
    base = s - (s % span);
    case (burst)
      2'd0:    return start;
      2'd2:    return AW'(base + ((s - base + 64'(i) * bytes) % span));
      default: return AW'(s + 64'(i) * bytes);
    endcase
  endfunction

  function automatic logic beat_err(input logic [AW-1:0] a, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
    return ((a >> 2) >= 32'(DEPTH)) || (size > 3'd2) || (burst == 2'd3) ||
           ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  task automatic aw_phase(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int cnt;
    wa_id = id; wa_addr = addr; wa_len = len; wa_size = size; wa_burst = burst;
    wa_beat = 0; wa_err = 1'b0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    cnt = 0;
    while (AWREADY !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) begin checks++; failures++; $display("FAIL aw_timeout awready=%b required 1", AWREADY); end
    @(negedge clk);
    AWVALID = 1'b0;
    checks++;
    if (WREADY !== 1'b1) begin failures++; $display("FAIL wready_latency wready=%b required 1", WREADY); end
  endtask

  task automatic w_beat(input logic [DW-1:0] data, input logic [3:0] strb, input logic last);
    logic [AW-1:0] a;
    logic e;
    int cnt;
    a = beat_addr(wa_addr, wa_len, wa_size, wa_burst, wa_beat);
    e = beat_err(a, wa_len, wa_size, wa_burst) || (last != (wa_beat == int'(wa_len)));
    if (!e) for (int b = 0; b < 4; b++) if (strb[b]) model[int'(a >> 2)][b*8 +: 8] = data[b*8 +: 8];
    wa_err = wa_err || e;
    wa_beat++;
    if (wa_beat == int'(wa_len) + 1) b_q.push_back('{id: wa_id, resp: wa_err ? 2'b10 : 2'b00});
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    cnt = 0;
    while (WREADY !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) begin checks++; failures++; $display("FAIL w_timeout wready=%b required 1", WREADY); end
    @(negedge clk);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_phase(input int hold);
    bexp_t ex;
    int cnt;
    cnt = 0;
    while (BVALID !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) begin checks++; failures++; $display("FAIL b_timeout bvalid=%b required 1", BVALID); return; end
    if (b_q.size() == 0) begin checks++; failures++; $display("FAIL b_unexpected bid=%0d required none", BID); return; end
    ex = b_q.pop_front();
    checks++;
    if ({BID, BRESP} !== {ex.id, ex.resp})
      begin failures++; $display("FAIL b_resp bid=%0d bresp=%0d required bid=%0d bresp=%0d", BID, BRESP, ex.id, ex.resp); end
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if ({BVALID, BID, BRESP} !== {1'b1, ex.id, ex.resp})
        begin failures++; $display("FAIL b_hold bvalid=%b bid=%0d bresp=%0d required 1/%0d/%0d", BVALID, BID, BRESP, ex.id, ex.resp); end
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    checks++;
    if (BVALID !== 1'b0) begin failures++; $display("FAIL b_idle bvalid=%b required 0", BVALID); end
  endtask

  task automatic ar_phase(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [AW-1:0] a;
    logic e;
    int cnt;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, len, size, burst, i);
      e = beat_err(a, len, size, burst);
      r_q.push_back('{id: id, data: e ? '0 : model[int'(a >> 2)], resp: e ? 2'b10 : 2'b00, last: (i == int'(len))});
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    cnt = 0;
    while (ARREADY !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    if (cnt >= 50) begin checks++; failures++; $display("FAIL ar_timeout arready=%b required 1", ARREADY); end
    @(negedge clk);
    ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1) begin failures++; $display("FAIL rvalid_latency rvalid=%b required 1", RVALID); end
  endtask

  task automatic r_phase(input int nbeats, input int stall_beat, input int stall_cycles);
    rexp_t ex;
    int cnt;
    for (int i = 0; i < nbeats; i++) begin
      cnt = 0;
      while (RVALID !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
      if (cnt >= 50) begin checks++; failures++; $display("FAIL r_timeout beat=%0d rvalid=%b required 1", i, RVALID); return; end
      if (r_q.size() == 0) begin checks++; failures++; $display("FAIL r_unexpected rdata=%h required none", RDATA); return; end
      ex = r_q.pop_front();
      checks++;
      if ({RID, RDATA, RRESP, RLAST} !== {ex.id, ex.data, ex.resp, ex.last})
        begin failures++; $display("FAIL r_beat%0d id=%0d data=%h resp=%0d last=%b required id=%0d data=%h resp=%0d last=%b",
                                   i, RID, RDATA, RRESP, RLAST, ex.id, ex.data, ex.resp, ex.last); end
      if (i == stall_beat) begin
        repeat (stall_cycles) begin
          @(negedge clk);
          checks++;
          if ({RVALID, RDATA, RLAST} !== {1'b1, ex.data, ex.last})
            begin failures++; $display("FAIL r_hold rvalid=%b data=%h required 1/%h", RVALID, RDATA, ex.data); end
        end
      end
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
    end
    checks++;
    if (RVALID !== 1'b0) begin failures++; $display("FAIL r_idle rvalid=%b required 0", RVALID); end
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [DW-1:0] base,
                          input logic [3:0] strb, input int hold);
    aw_phase(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) w_beat(base + DW'(i), strb, i == int'(len));
    b_phase(hold);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_beat, input int stall_cycles);
    ar_phase(id, addr, len, size, burst);
    r_phase(int'(len) + 1, stall_beat, stall_cycles);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, BRESP, RID, RDATA, RRESP} !== '0)
      begin failures++; $display("FAIL %s aw=%b w=%b b=%b ar=%b r=%b rl=%b bid=%0d bresp=%0d rid=%0d rdata=%h rresp=%0d required all 0",
                                 name, AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, BID, BRESP, RID, RDATA, RRESP); end
  endtask

  task automatic check_ready_rise();
    #1;
    checks++;
    if ({AWREADY, ARREADY} !== 2'b00) begin failures++; $display("FAIL ready_early aw=%b ar=%b required 00", AWREADY, ARREADY); end
    @(posedge clk); #1;
    checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID} !== 5'b11000)
      begin failures++; $display("FAIL ready_rise aw=%b ar=%b w=%b b=%b r=%b required 11000", AWREADY, ARREADY, WREADY, BVALID, RVALID); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    check_ready_rise();
  endtask

  task automatic test_incr();
    do_write(9'd3, 32'h10, 8'd3, 3'd2, 2'd1, 32'd1, 4'hf, 0);
    do_read(9'd5, 32'h10, 8'd3, 3'd2, 2'd1, -1, 0);
  endtask

  task automatic test_wrap();
    do_write(9'd7, 32'h38, 8'd3, 3'd2, 2'd2, 32'h100, 4'hf, 0);
    do_read(9'd8, 32'h30, 8'd3, 3'd2, 2'd1, -1, 0);
    do_read(9'd9, 32'h38, 8'd3, 3'd2, 2'd2, -1, 0);
  endtask

  task automatic test_strobe();
    do_write(9'd1, 32'h0, 8'd0, 3'd2, 2'd1, 32'h0, 4'hf, 0);
    do_write(9'd2, 32'h0, 8'd0, 3'd2, 2'd1, 32'hAABBCCDD, 4'b0101, 0);
    do_read(9'd2, 32'h0, 8'd0, 3'd2, 2'd1, -1, 0);
  endtask

  task automatic test_errors();
    do_write(9'd4, 32'h400, 8'd0, 3'd2, 2'd1, 32'h12345678, 4'hf, 0);
    do_read(9'd5, 32'h0, 8'd0, 3'd2, 2'd1, -1, 0);
    do_read(9'd6, 32'h400, 8'd0, 3'd2, 2'd1, -1, 0);
    do_read(9'd7, 32'h10, 8'd0, 3'd3, 2'd1, -1, 0);
    do_read(9'd8, 32'h30, 8'd2, 3'd2, 2'd2, -1, 0);
    do_write(9'd9, 32'h40, 8'd1, 3'd2, 2'd1, 32'h5000, 4'hf, 0);
    do_write(9'd9, 32'h40, 8'd1, 3'd2, 2'd3, 32'h6000, 4'hf, 0);
    do_read(9'd9, 32'h40, 8'd1, 3'd2, 2'd1, -1, 0);
    do_write(9'd10, 32'h48, 8'd1, 3'd2, 2'd1, 32'h7000, 4'hf, 0);
    aw_phase(9'd11, 32'h48, 8'd1, 3'd2, 2'd1);
    w_beat(32'hE0, 4'hf, 1'b1);
    w_beat(32'hE1, 4'hf, 1'b1);
    b_phase(0);
    do_read(9'd11, 32'h48, 8'd1, 3'd2, 2'd1, -1, 0);
  endtask

  task automatic test_backpressure();
    do_write(9'd20, 32'h60, 8'd3, 3'd2, 2'd1, 32'h600, 4'hf, 3);
    do_read(9'd21, 32'h60, 8'd3, 3'd2, 2'd1, 1, 5);
  endtask

  task automatic test_same_cycle();
    do_write(9'd30, 32'h20, 8'd0, 3'd2, 2'd1, 32'h11111111, 4'hf, 0);
    aw_phase(9'd31, 32'h20, 8'd0, 3'd2, 2'd1);
    r_q.push_back('{id: 9'd32, data: model[8], resp: 2'b00, last: 1'b1});
    ARID = 9'd32; ARADDR = 32'h20; ARLEN = 8'd0; ARSIZE = 3'd2; ARBURST = 2'd1; ARVALID = 1'b1;
    WDATA = 32'h22222222; WSTRB = 4'hf; WLAST = 1'b1; WVALID = 1'b1;
    checks++;
    if ({ARREADY, WREADY} !== 2'b11) begin failures++; $display("FAIL same_cycle_ready ar=%b w=%b required 11", ARREADY, WREADY); end
    @(negedge clk);
    ARVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    model[8] = 32'h22222222;
    b_q.push_back('{id: 9'd31, resp: 2'b00});
    r_phase(1, -1, 0);
    b_phase(0);
    do_read(9'd33, 32'h20, 8'd0, 3'd2, 2'd1, -1, 0);
  endtask

  task automatic test_reset_midburst();
    aw_phase(9'd40, 32'h80, 8'd3, 3'd2, 2'd1);
    ar_phase(9'd41, 32'h10, 8'd3, 3'd2, 2'd1);
    w_beat(32'hA1, 4'hf, 1'b0);
    w_beat(32'hA2, 4'hf, 1'b0);
    WDATA = 32'hA3; WSTRB = 4'hf; WVALID = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midburst");
    r_q.delete();
    b_q.delete();
    @(negedge clk);
    WVALID = 1'b0;
    rst_n = 1'b1;
    check_ready_rise();
    do_read(9'd42, 32'h80, 8'd1, 3'd2, 2'd1, -1, 0);
    do_write(9'd43, 32'h80, 8'd3, 3'd2, 2'd1, 32'hB0, 4'hf, 0);
    do_read(9'd44, 32'h80, 8'd3, 3'd2, 2'd1, -1, 0);
  endtask

  task automatic test_back_to_back();
    do_write(9'd50, 32'h90, 8'd7, 3'd2, 2'd2, 32'hC00, 4'hf, 0);
    do_write(9'd51, 32'hB0, 8'd1, 3'd2, 2'd0, 32'hD00, 4'hf, 0);
    do_read(9'd52, 32'h80, 8'd7, 3'd2, 2'd1, -1, 0);
    do_read(9'd53, 32'hB0, 8'd1, 3'd2, 2'd1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_errors();
    test_backpressure();
    test_same_cycle();
    test_reset_midburst();
    test_back_to_back();
    checks++;
    if (r_q.size() != 0 || b_q.size() != 0)
      begin failures++; $display("FAIL scoreboard_left r=%0d b=%0d required 0/0", r_q.size(), b_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
